// File: rtl/stopwatch_button_conditioner_if.sv
// Button conditioner bus.
// Purpose: bundles the three raw stopwatch buttons with their conditioned
// outputs so the conditioner and its consumer share one connection.
// Signals:
//   BTN_SOUTH   raw start/stop button, channel 0 (asynchronous, bouncing)
//   BTN_EAST    raw lap button, channel 1
//   BTN_NORTH   raw reset button, channel 2
//   level       debounced state per channel, 1 = pressed
//   press_pulse one-cycle strobe per channel on an accepted press
//   long_pulse  one-cycle strobe per channel when a press is held long enough
// Modports: master drives the buttons and observes the outputs; slave is the
// conditioner itself.
interface stopwatch_button_conditioner_if;
  logic       BTN_SOUTH;
  logic       BTN_EAST;
  logic       BTN_NORTH;
  logic [2:0] level;
  logic [2:0] press_pulse;
  logic [2:0] long_pulse;

  modport master (
    output BTN_SOUTH, BTN_EAST, BTN_NORTH,
    input  level, press_pulse, long_pulse
  );

  modport slave (
    input  BTN_SOUTH, BTN_EAST, BTN_NORTH,
    output level, press_pulse, long_pulse
  );
endinterface

// File: rtl/stopwatch_button_conditioner.sv
// Stopwatch button conditioner.
// Purpose: synchronizes and debounces three raw push buttons and produces,
// per channel, a debounced level, a one-cycle press strobe and a one-cycle
// long-press strobe.
// Ports:
//   CLK_50M  system clock, rising edge
//   reset    asynchronous, active-high reset
//   btn_if   slave side of the button bus (BTN_SOUTH/EAST/NORTH in,
//            level/press_pulse/long_pulse out, bit i = channel i)
// Parameters:
//   DEBOUNCE_CYCLES   stable synchronized samples needed to accept a change
//   LONG_PRESS_CYCLES cycles a debounced press is held before long_pulse
module stopwatch_button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic                          CLK_50M,
  input  logic                          reset,
  stopwatch_button_conditioner_if.slave btn_if
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                              DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  // One spare bit so the hold counter can park at LONG_PRESS_CYCLES.
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [2:0] btn_raw;
  logic [2:0] sync1_d, sync1_q;
  logic [2:0] sync2_d, sync2_q;

  assign btn_raw = {btn_if.BTN_NORTH, btn_if.BTN_EAST, btn_if.BTN_SOUTH};

  // Two-flop synchronizer; nothing else ever looks at btn_raw.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of the others.
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    state_e           state_d, state_q;
    logic [CNT_W-1:0] deb_cnt_d, deb_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d, hold_cnt_q;
    logic             level_d, level_q;
    logic             press_d, press_q;
    logic             long_d, long_q;
    logic             s;

    assign s = sync2_q[ch];

    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
      state_d    = state_q;
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      long_d     = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d   = PRESS_WAIT;
            deb_cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d    = PRESSED;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d   = RELEASE_WAIT;
            deb_cnt_d = '0;
          end else if (hold_cnt_q == LONG_LAST) begin
            // Jump past LONG_LAST so the strobe cannot repeat; the counter
            // then holds here until the next accepted press clears it.
            long_d     = 1'b1;
            hold_cnt_d = LONG_SAT;
          end else if (hold_cnt_q < LONG_LAST) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // A return to 1 is release bounce: resume the same press, keeping
          // the hold count and emitting no new strobe.
          if (s) begin
            state_d = PRESSED;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d = IDLE;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // NOTE: all state, counters and registered outputs are reset, so an event
    // in progress at reset is dropped without a strobe.
    always_ff @(posedge CLK_50M or posedge reset) begin
      if (reset) begin
        state_q    <= IDLE;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        long_q     <= long_d;
      end
    end

    assign btn_if.level[ch]       = level_q;
    assign btn_if.press_pulse[ch] = press_q;
    assign btn_if.long_pulse[ch]  = long_q;
  end

endmodule

// File: doc/stopwatch_button_conditioner.md
STOPWATCH_BUTTON_CONDITIONER -- requirements
Module: stopwatch_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 50000000, is the number of cycles a debounced press must be held before a long-press event (1 s at 50 MHz).
REQ-003 Port CLK_50M, input, 1 bit, is the single system clock; all logic is clocked on its rising edge.
REQ-004 Port reset, input, 1 bit, is the asynchronous, active-high reset.
REQ-005 Port BTN_SOUTH, input, 1 bit, is the raw start/stop button, asynchronous and bouncing; it maps to channel 0.
REQ-006 Port BTN_EAST, input, 1 bit, is the raw lap button; it maps to channel 1.
REQ-007 Port BTN_NORTH, input, 1 bit, is the raw reset button; it maps to channel 2.
REQ-008 Port level, output, 3 bits, is the debounced button state per channel (1 = pressed).
REQ-009 Port press_pulse, output, 3 bits, is a one-cycle strobe per channel on an accepted press.
REQ-010 Port long_pulse, output, 3 bits, is a one-cycle strobe per channel when a press reaches LONG_PRESS_CYCLES.

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flip-flop synchronizer before any other logic.
REQ-012 Each channel SHALL implement an independent FSM with four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In IDLE, a synchronized 1 SHALL move the FSM to PRESS_WAIT and clear the debounce counter.
REQ-014 In PRESS_WAIT, a synchronized 0 SHALL return the FSM to IDLE; otherwise the counter increments, and when it reaches DEBOUNCE_CYCLES-1 the FSM moves to PRESSED.
REQ-015 On entry to PRESSED: level[i] SHALL go to 1, press_pulse[i] SHALL be 1 for exactly one cycle, and the hold counter SHALL clear.
REQ-016 In PRESSED, a synchronized 0 SHALL move the FSM to RELEASE_WAIT and clear the debounce counter.
REQ-017 In PRESSED, when the hold counter reaches LONG_PRESS_CYCLES-1, long_pulse[i] SHALL be 1 for exactly one cycle.
  - The hold counter then saturates.
  - There is no further long_pulse until release.
REQ-018 In RELEASE_WAIT, a synchronized 1 SHALL return the FSM to PRESSED without a new press_pulse and without clearing the hold counter.
REQ-019 In RELEASE_WAIT, DEBOUNCE_CYCLES consecutive synchronized 0 samples SHALL move the FSM to IDLE with level[i] going to 0.
REQ-020 Press latency SHALL be exact: press_pulse[i] is high in the cycle following clock edge DEBOUNCE_CYCLES+3, where edge 1 is the first edge that samples the raw input high, provided the input stays high.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-022 Channels SHALL be fully independent; simultaneous presses on several channels SHALL produce simultaneous pulses in the same cycle.
REQ-023 Counter width SHALL be ceil(log2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)))+1 bits, and counters SHALL never wrap.
REQ-024 All outputs SHALL be registered, with no combinational path from the BTN_* inputs to any output.

Reset
REQ-025 While reset is 1, independent of CLK_50M, the following SHALL hold:
  - All FSMs are in IDLE.
  - Synchronizers and counters are 0.
  - level, press_pulse and long_pulse are 3'b000.
REQ-026 Reset deasserted while a button is held SHALL be treated as a fresh press, giving a press_pulse after the REQ-020 latency.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the event, with no pulse emitted.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-028 Clean press: BTN_SOUTH 0->1 and held -> press_pulse=3'b001 for one cycle at edge 7, level[0]=1 from then on, no long_pulse before edge 26.
REQ-029 Bounce: BTN_EAST toggles 1,0,1,0 every 2 cycles, then stays 1 -> exactly one press_pulse[1], timed from the final rising sample.
REQ-030 Long press: BTN_NORTH held 40 cycles -> one press_pulse[2], then one long_pulse[2] 20 cycles after it, then none.
REQ-031 Release bounce: after PRESSED, BTN_SOUTH drops for 2 cycles then returns -> level[0] stays 1, no second press_pulse.
REQ-032 Simultaneous: BTN_SOUTH and BTN_EAST rise on the same edge -> press_pulse=3'b011 in a single cycle.
REQ-033 Reset mid-debounce: BTN_EAST rises and reset pulses at edge 4 -> outputs 0 immediately; with BTN_EAST still held, press_pulse[1] occurs 7 edges after reset release.
